// File: rtl/sram_256x8.sv
// sram_256x8: single-port synchronous RAM with registered, write-through read data
module sram_256x8 #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr,
  input  logic              rd,
  input  logic              cs,
  output logic [DATA_W-1:0] dout
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_wr, do_rd;
  assign do_wr = cs && wr;
  assign do_rd = cs && !rd;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      dout <= '0;
    end else begin
      if (do_wr) mem[addr] <= din;
      dout <= do_rd ? (do_wr ? din : mem[addr]) : '0;
    end
  end
endmodule

// File: tb/tb_sram_256x8.sv
// tb_sram_256x8: scoreboard bench comparing sram_256x8 against an array reference model
module tb_sram_256x8;
  logic       clk = 0;
  logic       rst, wr, rd, cs;
  logic [7:0] din, addr, dout;
  int         errors = 0, checks = 0;
  int         ref_mem [256];
  bit         done = 0;
  typedef struct {
    logic [7:0] exp;
    string      name;
  } exp_t;
  exp_t sb [$];

  sram_256x8 dut (
    .clk(clk), .rst(rst), .din(din), .addr(addr),
    .wr(wr), .rd(rd), .cs(cs), .dout(dout)
  );

  always #5 clk = ~clk;

  task automatic step(input bit r, c, w, rn, input logic [7:0] a, d, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; cs = c; wr = w; rd = rn; addr = a; din = d;
    e.name = nm;
    if (r) begin
      foreach (ref_mem[i]) ref_mem[i] = 0;
      e.exp = 8'h00;
    end else begin
      if (c && !rn) e.exp = w ? d : 8'(ref_mem[a]);
      else e.exp = 8'h00;
      if (c && w) ref_mem[a] = int'(d);
    end
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (dout !== e.exp) begin
        errors++;
        $display("FAIL %s: dout=%h expected=%h at %0t", e.name, dout, e.exp, $time);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: stimulus did not finish by %0t", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
  end

  initial begin
    rst = 1; cs = 0; wr = 0; rd = 1; addr = 0; din = 0;
    foreach (ref_mem[i]) ref_mem[i] = $urandom_range(1, 255);
    step(1, 0, 0, 1, 8'h00, 8'h00, "reset");
    @(posedge clk);
    #2;
    checks++;
    if (dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: dout=%h expected=00 at %0t", dout, $time);
    end
    step(0, 1, 0, 0, 8'h00, 8'h00, "reset_rd_00");
    step(0, 1, 0, 0, 8'hFF, 8'h00, "reset_rd_ff");
    step(0, 1, 1, 1, 8'h05, 8'hA5, "wr_05");
    step(0, 1, 0, 0, 8'h05, 8'h00, "rd_05");
    step(0, 1, 1, 1, 8'h10, 8'h3C, "preload_10");
    step(0, 0, 1, 1, 8'h10, 8'hFF, "cs0_wr");
    step(0, 0, 0, 0, 8'h10, 8'h00, "cs0_rd");
    step(0, 1, 0, 0, 8'h10, 8'h00, "rd_10");
    step(0, 1, 1, 0, 8'h20, 8'h77, "wthru_20");
    step(0, 1, 0, 1, 8'h20, 8'h00, "idle");
    step(0, 1, 0, 0, 8'h20, 8'h00, "rd_20");
    for (int a = 0; a < 256; a++) step(0, 1, 1, 1, 8'(a), 8'(a), "sweep_wr");
    for (int a = 0; a < 256; a++) begin
      step(0, 1, 0, 0, 8'(a), 8'h00, "sweep_rd");
      step(0, 1, 0, 1, 8'(a), 8'h00, "sweep_idle");
    end
    step(1, 1, 1, 1, 8'h30, 8'h99, "rst_abort_wr");
    step(0, 1, 0, 0, 8'h30, 8'h00, "rd_30_after_rst");
    step(0, 1, 0, 0, 8'h05, 8'h00, "rd_05_after_rst");
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0, 1'($urandom),
           1'($urandom), a, 8'($urandom), "random");
    end
    repeat (3) @(negedge clk);
    done = 1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expectations never checked", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sram_256x8.md
Name: sram_256x8

Overview:
- Single-port synchronous static RAM, 256 words x 8 bits by default, for use as a general-purpose scratch store.
- Control is by chip select (active-high), write enable (active-high) and read enable (active-low).
- Address and data buses are separate.
- Read data is registered, and both read and write are fully synchronous to one clock.

Parameters:
- DATA_W, 8, width of din/dout and of each memory word.
- ADDR_W, 8, width of addr.
- DEPTH, 256, number of words; must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous reset, active-high.
- din  input  DATA_W  write data.
- addr  input  ADDR_W  word address for both read and write.
- wr  input  1  write enable, active-high.
- rd  input  1  read enable, active-low.
- cs  input  1  chip select, active-high; when low, the block ignores wr/rd.
- dout  output  DATA_W  registered read data.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: on a rising clk edge with rst=1:
  - dout <= 0.
  - Every memory word <= 0; the clear completes in that single edge.
  - wr/rd/cs are ignored in that cycle.
  - Reset applied mid-operation aborts any write in that cycle, so the word is not written.
- Write: on a rising edge with rst=0, cs=1, wr=1: mem[addr] <= din. Latency 1 cycle; a read of the same address on the next cycle returns the new data.
- Read: on a rising edge with rst=0, cs=1, rd=0: dout <= mem[addr].
  - Latency 1 cycle: data is valid the cycle after rd is sampled low.
- Simultaneous read and write (cs=1, wr=1, rd=0) to the same edge: the write is performed and dout <= din (write-through/bypass), not the old contents.
- Idle: when cs=0, or cs=1 with wr=0 and rd=1:
  - Memory is unchanged.
  - dout <= 0 (the output is driven low, never high-Z, never holds stale data).
- cs=0 blocks writes regardless of wr, and blocks reads regardless of rd.
- Address: the full addr range 0..DEPTH-1 is valid; there is no wrap or out-of-range case at defaults.
- X/undefined inputs are not required to be handled; the bench drives only 0/1.
- Memory contents persist indefinitely without refresh until overwritten or reset.

Test Plan:
- Reset: pulse rst=1 for 1 cycle, then read addr 8'h00 and 8'hFF with cs=1, rd=0 -> dout=8'h00 each, one cycle after each read.
- Basic write/read: cs=1, wr=1, addr=8'h05, din=8'hA5; next cycle wr=0, rd=0, addr=8'h05 -> dout=8'hA5 one cycle later.
- Chip select gating:
  - Preload mem[8'h10]=8'h3C.
  - cs=0, wr=1, addr=8'h10, din=8'hFF for 1 cycle -> no write.
  - Then cs=1, rd=0 -> dout=8'h3C.
  - While cs=0, dout=8'h00.
- Write-through: cs=1, wr=1, rd=0, addr=8'h20, din=8'h77 -> dout=8'h77 next cycle; a later plain read of 8'h20 -> 8'h77.
- Sweep: write din=addr for addr 0..255, then read back all 256 -> dout equals the address each time; idle cycles between reads give dout=8'h00.
- Reset mid-operation: rst=1 coinciding with cs=1, wr=1, addr=8'h30, din=8'h99 -> a following read of 8'h30 gives 8'h00.
